// File: rtl/fsb_cycle_pkg.sv
// Shared types for the front-side bus cycle sequencer: FSM states, decoded target
// and select-decode helpers.
package fsb_cycle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_ROM,
        TGT_IO
    } tgt_e;

    // True when exactly one of the three selects is high.
    function automatic logic sel_onehot(input logic ram, input logic rom, input logic io);
        return (ram ^ rom ^ io) & ~(ram & rom & io);
    endfunction

    function automatic tgt_e sel_target(input logic ram, input logic rom, input logic io);
        tgt_e t;
        t = TGT_NONE;
        if (ram)      t = TGT_RAM;
        else if (rom) t = TGT_ROM;
        else if (io)  t = TGT_IO;
        return t;
    endfunction

endpackage

// File: rtl/fsb_wait_counter.sv
// Down-counter for wait states / I/O timeout; load has priority over decrement.
// Single-cycle update, zero flag is combinational from the register; no backpressure.
module fsb_wait_counter #(
    parameter int CNT_W = 8
) (
    input  logic             FCLK,
    input  logic             nRES,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] din,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = din;
        end else if (dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fsb_cycle_ctl.sv
// MC68HC000 bus cycle sequencer: wait states for RAM/ROM, I/O handshake with timeout,
// decode errors. All outputs registered; a cycle is held in DONE/ERR until BACT drops.
module fsb_cycle_ctl
    import fsb_cycle_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int RAM_WS     = 0,
    parameter int ROM_WS     = 2,
    parameter int IO_TIMEOUT = 255
) (
    input  logic FCLK,
    input  logic nRES,
    input  logic BACT,
    input  logic RAMCS,
    input  logic ROMCS,
    input  logic IOCS,
    input  logic IOACK,
    input  logic TOClr,
    output logic Ready,
    output logic BERR0,
    output logic BERR1,
    output logic IOStart,
    output logic TOErr
);

    localparam logic [CNT_W-1:0] RAM_LD = CNT_W'(RAM_WS);
    localparam logic [CNT_W-1:0] ROM_LD = CNT_W'(ROM_WS);
    // The load edge itself consumes one of the timeout cycles.
    localparam logic [CNT_W-1:0] IO_LD  = CNT_W'(IO_TIMEOUT - 1);

    state_e           state_q, state_d;
    tgt_e             tgt_q, tgt_d;
    logic             ready_q, ready_d;
    logic             berr0_q, berr0_d;
    logic             berr1_q, berr1_d;
    logic             iostart_q, iostart_d;
    logic             toerr_q, toerr_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_din;
    logic             cnt_zero;
    tgt_e             sel_tgt;
    logic             sel_ok;

    fsb_wait_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .FCLK (FCLK),
        .nRES (nRES),
        .load (cnt_load),
        .dec  (cnt_dec),
        .din  (cnt_din),
        .zero (cnt_zero)
    );

    assign sel_ok  = sel_onehot(RAMCS, ROMCS, IOCS);
    assign sel_tgt = sel_target(RAMCS, ROMCS, IOCS);

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        ready_d   = ready_q;
        berr0_d   = berr0_q;
        berr1_d   = berr1_q;
        iostart_d = 1'b0;
        toerr_d   = toerr_q & ~TOClr;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_din   = '0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                berr0_d = 1'b0;
                berr1_d = 1'b0;
                if (BACT) begin
                    if (sel_ok) begin
                        state_d  = WAIT;
                        tgt_d    = sel_tgt;
                        cnt_load = 1'b1;
                        case (sel_tgt)
                            TGT_RAM: cnt_din = RAM_LD;
                            TGT_ROM: cnt_din = ROM_LD;
                            default: cnt_din = IO_LD;
                        endcase
                        iostart_d = (sel_tgt == TGT_IO);
                    end else begin
                        state_d = ERR;
                        tgt_d   = TGT_NONE;
                        berr1_d = 1'b1;
                    end
                end
            end

            WAIT: begin
                if (!BACT) begin
                    // Abort: zero the counter so a stale count never leaks into the next cycle.
                    state_d  = IDLE;
                    tgt_d    = TGT_NONE;
                    ready_d  = 1'b0;
                    berr0_d  = 1'b0;
                    berr1_d  = 1'b0;
                    cnt_load = 1'b1;
                end else if (tgt_q == TGT_IO) begin
                    if (IOACK) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                    end else if (cnt_zero) begin
                        state_d = ERR;
                        berr0_d = 1'b1;
                        toerr_d = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end else if (tgt_q == TGT_NONE) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: begin
                if (!BACT) begin
                    state_d = IDLE;
                    tgt_d   = TGT_NONE;
                    ready_d = 1'b0;
                    berr0_d = 1'b0;
                    berr1_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            state_q   <= IDLE;
            tgt_q     <= TGT_NONE;
            ready_q   <= 1'b0;
            berr0_q   <= 1'b0;
            berr1_q   <= 1'b0;
            iostart_q <= 1'b0;
            toerr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            ready_q   <= ready_d;
            berr0_q   <= berr0_d;
            berr1_q   <= berr1_d;
            iostart_q <= iostart_d;
            toerr_q   <= toerr_d;
        end
    end

    assign Ready   = ready_q;
    assign BERR0   = berr0_q;
    assign BERR1   = berr1_q;
    assign IOStart = iostart_q;
    assign TOErr   = toerr_q;

endmodule

// File: tb/tb_fsb_cycle_ctl.sv
// Bench for fsb_cycle_ctl: directed cycles then randomized cycles, each edge compared
// against an edge-number timeline model of the bus cycle.
module tb_fsb_cycle_ctl;

    localparam int RAM_WS = 0;
    localparam int ROM_WS = 2;
    localparam int TMO    = 8;

    logic FCLK  = 1'b0;
    logic nRES  = 1'b0;
    logic BACT  = 1'b0;
    logic RAMCS = 1'b0;
    logic ROMCS = 1'b0;
    logic IOCS  = 1'b0;
    logic IOACK = 1'b0;
    logic TOClr = 1'b0;
    logic Ready, BERR0, BERR1, IOStart, TOErr;

    int   total = 0;
    int   bad   = 0;
    logic m_toerr = 1'b0;

    always #5 FCLK = ~FCLK;

    fsb_cycle_ctl #(
        .CNT_W      (8),
        .RAM_WS     (RAM_WS),
        .ROM_WS     (ROM_WS),
        .IO_TIMEOUT (TMO)
    ) dut (
        .FCLK    (FCLK),
        .nRES    (nRES),
        .BACT    (BACT),
        .RAMCS   (RAMCS),
        .ROMCS   (ROMCS),
        .IOCS    (IOCS),
        .IOACK   (IOACK),
        .TOClr   (TOClr),
        .Ready   (Ready),
        .BERR0   (BERR0),
        .BERR1   (BERR1),
        .IOStart (IOStart),
        .TOErr   (TOErr)
    );

    // Output vector order: {Ready, BERR0, BERR1, IOStart, TOErr}
    task automatic check(input string tag, input int e, input logic [4:0] exp);
        logic [4:0] got;
        got = {Ready, BERR0, BERR1, IOStart, TOErr};
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s edge=%0d got=%b exp=%b", tag, e, got, exp);
        end
    endtask

    // One bus cycle: edge 0 samples BACT=1 in IDLE with the given selects {RAM,ROM,IO};
    // BACT stays high for 'hold' edges, the edge 'hold' sees BACT=0. ack>0 raises IOACK
    // from that edge on (IO only); clr_at pulses TOClr on that edge.
    task automatic run_cycle(input string tag, input logic [2:0] sel, input int hold,
                             input int ack, input int clr_at);
        int   nsel;
        int   fin;
        bit   acked;
        logic r, b0, b1, st;
        nsel  = int'(sel[2]) + int'(sel[1]) + int'(sel[0]);
        acked = (ack > 0) && (ack <= TMO);
        fin   = acked ? ack : TMO;
        for (int e = 0; e <= hold; e++) begin
            BACT = (e < hold);
            if (e == 0) {RAMCS, ROMCS, IOCS} = sel;
            else        {RAMCS, ROMCS, IOCS} = 3'($urandom);
            if (sel == 3'b001) IOACK = (ack > 0) && (e >= ack);
            else               IOACK = 1'($urandom);
            TOClr = (e == clr_at);
            @(posedge FCLK);
            r = 1'b0; b0 = 1'b0; b1 = 1'b0; st = 1'b0;
            if (e < hold) begin
                if (nsel != 1) begin
                    b1 = 1'b1;
                end else if (sel == 3'b001) begin
                    st = (e == 0);
                    if (e >= fin) begin
                        if (acked) r = 1'b1;
                        else       b0 = 1'b1;
                    end
                end else if (e >= 1 + (sel[2] ? RAM_WS : ROM_WS)) begin
                    r = 1'b1;
                end
            end
            if (sel == 3'b001 && !acked && e == TMO && e < hold) m_toerr = 1'b1;
            else if (e == clr_at)                                 m_toerr = 1'b0;
            @(negedge FCLK);
            check(tag, e, {r, b0, b1, st, m_toerr});
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int e = 0; e < n; e++) begin
            BACT  = 1'b0;
            {RAMCS, ROMCS, IOCS} = 3'($urandom);
            IOACK = 1'($urandom);
            TOClr = 1'($urandom);
            @(posedge FCLK);
            if (TOClr) m_toerr = 1'b0;
            @(negedge FCLK);
            check(tag, e, {4'b0000, m_toerr});
        end
    endtask

    initial begin
        logic [2:0] sel;
        int         hold, ack, clr;

        #3;
        check("reset", 0, 5'b00000);
        @(negedge FCLK);
        nRES = 1'b1;
        @(negedge FCLK);
        check("after_release", 0, 5'b00000);

        run_cycle("ram_ws0",     3'b100, 3, 0, -1);
        run_cycle("rom_ws2",     3'b010, 5, 0, -1);
        run_cycle("rom_abort",   3'b010, 2, 0, -1);
        run_cycle("io_ack4",     3'b001, 6, 4, -1);
        run_cycle("io_timeout",  3'b001, 10, 0, -1);
        run_cycle("io_race",     3'b001, 10, 8, -1);
        run_cycle("dec_ramrom",  3'b110, 2, 0, -1);
        run_cycle("dec_none",    3'b000, 3, 0, -1);
        run_cycle("dec_all",     3'b111, 1, 0, -1);
        run_cycle("toclr_race",  3'b001, 9, 0, 8);
        run_cycle("toclr_alone", 3'b100, 3, 0, 1);
        run_cycle("io_abort",    3'b001, 3, 5, -1);
        idle("idle_gap", 2);

        for (int i = 0; i < 60; i++) begin
            sel  = 3'($urandom);
            hold = $urandom_range(1, 12);
            ack  = $urandom_range(0, 11);
            clr  = $urandom_range(0, 15);
            run_cycle("rand", sel, hold, ack, clr);
            if ($urandom_range(0, 3) == 0) idle("rand_gap", $urandom_range(1, 3));
        end

        // Set TOErr, then reset asynchronously in the middle of an I/O WAIT.
        run_cycle("pre_reset_to", 3'b001, 9, 0, -1);
        BACT = 1'b1; {RAMCS, ROMCS, IOCS} = 3'b001; IOACK = 1'b0; TOClr = 1'b0;
        repeat (3) @(posedge FCLK);
        @(negedge FCLK);
        #1 nRES = 1'b0;
        #1;
        m_toerr = 1'b0;
        check("async_reset", 0, 5'b00000);
        BACT = 1'b0;
        @(negedge FCLK);
        check("in_reset", 0, 5'b00000);
        nRES = 1'b1;
        run_cycle("ram_after_reset", 3'b100, 3, 0, -1);
        run_cycle("rom_after_reset", 3'b010, 4, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
